// File: rtl/r_alu_share_arbiter.sv
// r_alu_share_arbiter
// Shares one external combinational R-type ALU between NUM_REQ requesters.
// Round-robin grant, per-requester valid/ready, one-entry registered response
// buffer with backpressure.
// Optional build macro: R_ALU_ARB_ILLEGAL_CHECK_EN
//   defined   - func is decoded at grant; non-R encodings return rsp_illegal=1
//               and rsp_data=0, ignoring alu_result.
//   undefined - no decode; rsp_data always takes alu_result, rsp_illegal is 0.
module r_alu_share_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [5*NUM_REQ-1:0]    req_func,
  input  logic [32*NUM_REQ-1:0]   req_rs1,
  input  logic [32*NUM_REQ-1:0]   req_rs2,
  output logic [4:0]              alu_func,
  output logic [31:0]             alu_rs1,
  output logic [31:0]             alu_rs2,
  input  logic [31:0]             alu_result,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [31:0]             rsp_data,
  output logic                    rsp_illegal
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t          state_q;
  logic [ID_W-1:0] rrPtr_q;
  logic [ID_W-1:0] rspId_q;
  logic [31:0]     rspData_q;
  logic            rspIllegal_q;

  logic            canIssue;
  logic            hiFound;
  logic            loFound;
  logic [ID_W-1:0] hiIdx;
  logic [ID_W-1:0] loIdx;
  logic            gntValid;
  logic [ID_W-1:0] gntIdx;
  logic [ID_W-1:0] rrPtr_d;
  logic [31:0]     rspData_d;
  logic            rspIllegal_d;

  // A new operation may be taken only if the buffer is empty or drains this cycle.
  assign canIssue = (state_q == EMPTY) | rsp_ready;

  // Round-robin scan: lowest valid index at or above the pointer wins, else lowest below it.
  always_comb begin
    hiFound = 1'b0;
    loFound = 1'b0;
    hiIdx   = '0;
    loIdx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        if (ID_W'(i) >= rrPtr_q) begin
          hiFound = 1'b1;
          hiIdx   = ID_W'(i);
        end else begin
          loFound = 1'b1;
          loIdx   = ID_W'(i);
        end
      end
    end
    gntValid = canIssue & ~rst & (hiFound | loFound);
    gntIdx   = hiFound ? hiIdx : loIdx;
  end

  // One-hot ready and operand mux toward the shared ALU; all zero without a grant.
  always_comb begin
    req_ready = '0;
    alu_func  = '0;
    alu_rs1   = '0;
    alu_rs2   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gntValid && (gntIdx == ID_W'(i))) begin
        req_ready[i] = 1'b1;
        alu_func     = req_func[5*i +: 5];
        alu_rs1      = req_rs1[32*i +: 32];
        alu_rs2      = req_rs2[32*i +: 32];
      end
    end
  end

  // Pointer moves to the requester after the one just granted, wrapping to zero.
  assign rrPtr_d = (gntIdx == ID_W'(NUM_REQ - 1)) ? '0 : gntIdx + ID_W'(1);

`ifdef R_ALU_ARB_ILLEGAL_CHECK_EN
  function automatic logic isLegal(input logic [4:0] f);
    case (f)
      5'b00000, 5'b10000, 5'b00001, 5'b00010, 5'b00011,
      5'b00100, 5'b00101, 5'b10101, 5'b00110, 5'b00111: isLegal = 1'b1;
      default:                                           isLegal = 1'b0;
    endcase
  endfunction

  assign rspIllegal_d = ~isLegal(alu_func);
  assign rspData_d    = rspIllegal_d ? 32'd0 : alu_result;
`else
  assign rspIllegal_d = 1'b0;
  assign rspData_d    = alu_result;
`endif

  // Buffer FSM: load on grant, drain on rsp_ready, refill in the same cycle when both happen.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= EMPTY;
      rrPtr_q      <= '0;
      rspId_q      <= '0;
      rspData_q    <= '0;
      rspIllegal_q <= 1'b0;
    end else begin
      if (gntValid) begin
        state_q      <= FULL;
        rrPtr_q      <= rrPtr_d;
        rspId_q      <= gntIdx;
        rspData_q    <= rspData_d;
        rspIllegal_q <= rspIllegal_d;
      end else if ((state_q == FULL) && rsp_ready) begin
        state_q <= EMPTY;
      end
    end
  end

  assign rsp_valid   = (state_q == FULL);
  assign rsp_id      = rspId_q;
  assign rsp_data    = rspData_q;
  assign rsp_illegal = rspIllegal_q;

endmodule

// File: tb/tb_r_alu_share_arbiter.sv
// tb_r_alu_share_arbiter
// Directed bench for r_alu_share_arbiter (NUM_REQ=2) with a transaction-level
// reference model checked every cycle plus hand-computed literal checks.
module tb_r_alu_share_arbiter;

  localparam int NUM_REQ = 2;
  localparam int ID_W    = 3;

  logic                  clk;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [5*NUM_REQ-1:0]  req_func;
  logic [32*NUM_REQ-1:0] req_rs1;
  logic [32*NUM_REQ-1:0] req_rs2;
  logic [4:0]            alu_func;
  logic [31:0]           alu_rs1;
  logic [31:0]           alu_rs2;
  logic [31:0]           alu_result;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [31:0]           rsp_data;
  logic                  rsp_illegal;

  int  assertCount = 0;
  int  failCount   = 0;
  bit  checkEn     = 1'b0;

  r_alu_share_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_func    (req_func),
    .req_rs1     (req_rs1),
    .req_rs2     (req_rs2),
    .alu_func    (alu_func),
    .alu_rs1     (alu_rs1),
    .alu_rs2     (alu_rs2),
    .alu_result  (alu_result),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_data    (rsp_data),
    .rsp_illegal (rsp_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference RV32I R-type ALU; unknown encodings give a recognisable nonzero pattern.
  function automatic logic [31:0] refAlu(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      5'b00000: return a + b;
      5'b10000: return a - b;
      5'b00001: return a << b[4:0];
      5'b00010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'b00011: return (a < b) ? 32'd1 : 32'd0;
      5'b00100: return a ^ b;
      5'b00101: return a >> b[4:0];
      5'b10101: return 32'($signed(a) >>> b[4:0]);
      5'b00110: return a | b;
      5'b00111: return a & b;
      default:  return a ^ 32'hDEAD_BEEF;
    endcase
  endfunction

  // Membership in the table of legal R encodings.
  function automatic logic isLegalFunc(input logic [4:0] f);
    logic [4:0] legal [10];
    legal = '{5'b00000, 5'b10000, 5'b00001, 5'b00010, 5'b00011,
              5'b00100, 5'b00101, 5'b10101, 5'b00110, 5'b00111};
    foreach (legal[k]) if (legal[k] == f) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic expIllegal(input logic [4:0] f);
`ifdef R_ALU_ARB_ILLEGAL_CHECK_EN
    return ~isLegalFunc(f);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] expData(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
    return expIllegal(f) ? 32'd0 : refAlu(f, a, b);
  endfunction

  // Which requester should be served this cycle: -1 when none may be.
  function automatic int expGrant(input logic r, input logic full, input logic rdy,
                                  input int ptr, input logic [NUM_REQ-1:0] v);
    if (r) return -1;
    if (full && !rdy) return -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      int i = (ptr + k) % NUM_REQ;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  logic        mValid;
  int          mId;
  logic [31:0] mData;
  logic        mIll;
  int          mPtr;
  int          gNow;

  // The bench owns the ALU: result follows whatever operands the arbiter presents.
  always_comb alu_result = refAlu(alu_func, alu_rs1, alu_rs2);

  // Model decision for the current cycle.
  always_comb gNow = expGrant(rst, mValid, rsp_ready, mPtr, req_valid);

  // Model advances on each rising edge: hold one response slot and a rotating pointer.
  always @(posedge clk) begin
    if (rst) begin
      mValid <= 1'b0;
      mId    <= 0;
      mData  <= 32'd0;
      mIll   <= 1'b0;
      mPtr   <= 0;
    end else if (gNow >= 0) begin
      mValid <= 1'b1;
      mId    <= gNow;
      mData  <= expData(req_func[5*gNow +: 5], req_rs1[32*gNow +: 32], req_rs2[32*gNow +: 32]);
      mIll   <= expIllegal(req_func[5*gNow +: 5]);
      mPtr   <= (gNow + 1) % NUM_REQ;
    end else if (mValid && rsp_ready) begin
      mValid <= 1'b0;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle: compare DUT outputs against the model on the falling edge.
  always @(negedge clk) begin
    if (checkEn) begin
      if (gNow < 0) begin
        checkOutput("mdl_req_ready", 32'(req_ready), 32'd0);
        checkOutput("mdl_alu_func", 32'(alu_func), 32'd0);
        checkOutput("mdl_alu_rs1", alu_rs1, 32'd0);
        checkOutput("mdl_alu_rs2", alu_rs2, 32'd0);
      end else begin
        checkOutput("mdl_req_ready", 32'(req_ready), 32'(1) << gNow);
        checkOutput("mdl_alu_func", 32'(alu_func), 32'(req_func[5*gNow +: 5]));
        checkOutput("mdl_alu_rs1", alu_rs1, req_rs1[32*gNow +: 32]);
        checkOutput("mdl_alu_rs2", alu_rs2, req_rs2[32*gNow +: 32]);
      end
      checkOutput("mdl_rsp_valid", 32'(rsp_valid), 32'(mValid));
      if (mValid) begin
        checkOutput("mdl_rsp_id", 32'(rsp_id), 32'(mId));
        checkOutput("mdl_rsp_data", rsp_data, mData);
        checkOutput("mdl_rsp_illegal", 32'(rsp_illegal), 32'(mIll));
      end
    end
  end

  task automatic applyStimulus(input logic [1:0] valid,
                               input logic [4:0] f0, input logic [31:0] a0, input logic [31:0] b0,
                               input logic [4:0] f1, input logic [31:0] a1, input logic [31:0] b1,
                               input logic rdy);
    req_valid = valid;
    req_func  = {f1, f0};
    req_rs1   = {a1, a0};
    req_rs2   = {b1, b0};
    rsp_ready = rdy;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held two cycles with both requesters asking.
    rst = 1'b1;
    applyStimulus(2'b11, 5'b10000, 32'd5, 32'd7, 5'b00000, 32'd10, 32'd20, 1'b1);
    stepCycle();
    checkEn = 1'b1;
    stepCycle();
    @(negedge clk);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_rsp_data", rsp_data, 32'd0);
    checkOutput("rst_rsp_illegal", 32'(rsp_illegal), 32'd0);
    stepCycle();

    // First grant after release goes to requester 0; SUB 5-7.
    rst = 1'b0;
    @(negedge clk);
    checkOutput("first_grant", 32'(req_ready), 32'd1);
    stepCycle();
    applyStimulus(2'b10, 5'b10000, 32'd5, 32'd7, 5'b00000, 32'd10, 32'd20, 1'b1);
    @(negedge clk);
    checkOutput("sub_rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("sub_rsp_id", 32'(rsp_id), 32'd0);
    checkOutput("sub_rsp_data", rsp_data, 32'hFFFF_FFFE);
    checkOutput("second_grant", 32'(req_ready), 32'd2);
    stepCycle();
    applyStimulus(2'b00, 5'b0, 32'd0, 32'd0, 5'b0, 32'd0, 32'd0, 1'b1);
    @(negedge clk);
    checkOutput("add_rsp_id", 32'(rsp_id), 32'd1);
    checkOutput("add_rsp_data", rsp_data, 32'd30);
    stepCycle();

    // Round robin with both requesters valid every cycle.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(2'b11, 5'b00100, 32'(k), 32'hF0F0_0000, 5'b00010, 32'(-k), 32'd1, 1'b1);
      @(negedge clk);
      checkOutput("rr_grant", 32'(req_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
      if (k > 0) checkOutput("rr_rsp_id", 32'(rsp_id), 32'((k - 1) % 2));
      stepCycle();
    end
    applyStimulus(2'b00, 5'b0, 32'd0, 32'd0, 5'b0, 32'd0, 32'd0, 1'b1);
    @(negedge clk);
    checkOutput("rr_last_id", 32'(rsp_id), 32'd1);
    stepCycle();

    // Backpressure: SRA result held while no grants are issued.
    applyStimulus(2'b01, 5'b10101, 32'h8000_0000, 32'd4, 5'b0, 32'd0, 32'd0, 1'b1);
    @(negedge clk);
    checkOutput("bp_first_grant", 32'(req_ready), 32'd1);
    stepCycle();
    applyStimulus(2'b11, 5'b00110, 32'd1, 32'd2, 5'b00111, 32'hFF, 32'hF, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("bp_req_ready", 32'(req_ready), 32'd0);
      checkOutput("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      checkOutput("bp_rsp_data", rsp_data, 32'hF800_0000);
      stepCycle();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_release_grant", 32'(req_ready), 32'd2);
    stepCycle();
    applyStimulus(2'b00, 5'b0, 32'd0, 32'd0, 5'b0, 32'd0, 32'd0, 1'b1);
    @(negedge clk);
    checkOutput("bp_and_data", rsp_data, 32'hF);
    stepCycle();

    // Illegal encoding from requester 1.
    applyStimulus(2'b10, 5'b0, 32'd0, 32'd0, 5'b11000, 32'd3, 32'd4, 1'b1);
    @(negedge clk);
    checkOutput("ill_grant", 32'(req_ready), 32'd2);
    stepCycle();
    applyStimulus(2'b00, 5'b0, 32'd0, 32'd0, 5'b0, 32'd0, 32'd0, 1'b1);
    @(negedge clk);
    checkOutput("ill_rsp_valid", 32'(rsp_valid), 32'd1);
`ifdef R_ALU_ARB_ILLEGAL_CHECK_EN
    checkOutput("ill_flag", 32'(rsp_illegal), 32'd1);
    checkOutput("ill_data", rsp_data, 32'd0);
`else
    checkOutput("ill_flag", 32'(rsp_illegal), 32'd0);
    checkOutput("ill_data", rsp_data, 32'hDEAD_BEEC);
`endif
    stepCycle();

    // Reset while a response is pending: it is dropped and the pointer restarts at 0.
    applyStimulus(2'b01, 5'b00000, 32'd1, 32'd2, 5'b0, 32'd0, 32'd0, 1'b1);
    stepCycle();
    applyStimulus(2'b00, 5'b0, 32'd0, 32'd0, 5'b0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    checkOutput("mid_rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("mid_rsp_data", rsp_data, 32'd3);
    stepCycle();
    rst = 1'b1;
    applyStimulus(2'b11, 5'b0, 32'd0, 32'd0, 5'b0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    checkOutput("mid_rst_ready", 32'(req_ready), 32'd0);
    stepCycle();
    rst = 1'b0;
    applyStimulus(2'b00, 5'b0, 32'd0, 32'd0, 5'b0, 32'd0, 32'd0, 1'b1);
    @(negedge clk);
    checkOutput("mid_rst_dropped", 32'(rsp_valid), 32'd0);
    stepCycle();
    applyStimulus(2'b11, 5'b00001, 32'd1, 32'd31, 5'b00011, 32'd1, 32'hFFFF_FFFF, 1'b1);
    @(negedge clk);
    checkOutput("mid_rst_still_empty", 32'(rsp_valid), 32'd0);
    checkOutput("mid_rst_ptr0", 32'(req_ready), 32'd1);
    stepCycle();

    // Sweep of all legal ops with a toggling consumer; the model checks every cycle.
    for (int k = 0; k < 20; k++) begin
      logic [4:0] ops [10];
      ops = '{5'b00000, 5'b10000, 5'b00001, 5'b00010, 5'b00011,
              5'b00100, 5'b00101, 5'b10101, 5'b00110, 5'b00111};
      applyStimulus((k % 3 == 2) ? 2'b01 : 2'b11,
                    ops[k % 10], 32'h8765_4321 + 32'(k), 32'(k * 3),
                    ops[(k + 5) % 10], 32'(-(k * 7)), 32'h1234_0000 + 32'(k),
                    (k % 4) != 1);
      stepCycle();
    end
    applyStimulus(2'b00, 5'b0, 32'd0, 32'd0, 5'b0, 32'd0, 32'd0, 1'b1);
    stepCycle();
    stepCycle();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
